// File: rtl/gauss_pkg.sv
// gauss_pkg: shared types and constants for the Gaussian pass scheduler
// Contents: state_t (sequencer states), KW (kernel-select width), frm() (frame size in pixels).
package gauss_pkg;
  localparam int KW = 3;
  typedef enum logic [2:0] {IDLE, CLR, STREAM, FLUSH, DRAIN, NEXT, DONE} state_t;
  function automatic int frm(int w, int h);
    return w * h;
  endfunction
endpackage

// File: rtl/gauss_pass_sched_if.sv
// gauss_pass_sched_if: scale-space memory and filter bus of the pass scheduler
// Memory: rd_en/rd_addr/rd_data (1-cycle read latency), wr_en/wr_addr/wr_data.
// Filter: filt_rst (active-low), filt_valid/filt_data in, filt_kern select, filt_vout/filt_dout out.
// master = scheduler side, slave = memory/filter side.
interface gauss_pass_sched_if
  import gauss_pkg::*;
#(
  parameter int AW = 20,
  parameter int DW = 16
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          filt_rst;
  logic          filt_valid;
  logic [DW-1:0] filt_data;
  logic [KW-1:0] filt_kern;
  logic          filt_vout;
  logic [DW-1:0] filt_dout;
  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, filt_rst, filt_valid, filt_data, filt_kern,
    input  rd_data, filt_vout, filt_dout
  );
  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, filt_rst, filt_valid, filt_data, filt_kern,
    output rd_data, filt_vout, filt_dout
  );
endinterface

// File: rtl/gauss_addr_gen.sv
// gauss_addr_gen: frame address = (scale+BASE_OFS)*FRM + row*WIDE + col, with linear pixel offset
// Ports: clk, rst (sync, active-low), clr (restart frame), inc (advance one pixel),
//        scale (pass index), addr (memory address), off (pixels advanced since clr).
module gauss_addr_gen
  import gauss_pkg::*;
#(
  parameter int WIDE     = 230,
  parameter int HIGN     = 235,
  parameter int CNT_DW   = 16,
  parameter int AW       = 20,
  parameter int BASE_OFS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  input  logic [KW-1:0] scale,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] off
);
  localparam logic [AW-1:0] FRM_A = AW'(frm(WIDE, HIGN));
  localparam logic [CNT_DW-1:0] COL_END = CNT_DW'(WIDE - 1);
  localparam logic [CNT_DW-1:0] ROW_END = CNT_DW'(HIGN - 1);
  logic [CNT_DW-1:0] row, col;
  always_ff @(posedge clk)
    if (!rst || clr) begin
      off <= '0;
      row <= '0;
      col <= '0;
    end else if (inc) begin
      off <= off + 1'b1;
      col <= (col == COL_END) ? '0 : col + 1'b1;
      row <= (col != COL_END) ? row : (row == ROW_END) ? '0 : row + 1'b1;
    end
  // row/col drive the in-frame offset so the debug position always matches the address
  assign addr = (AW'(scale) + AW'(BASE_OFS)) * FRM_A + AW'(row) * AW'(WIDE) + AW'(col);
endmodule

// File: rtl/gauss_pass_sched.sv
// gauss_pass_sched: time-shares one Gaussian filter over the NSCALE passes of a SIFT octave
// Ports: clk, rst (sync, active-low), start (octave start, IDLE only), busy, done (1-cycle pulse),
//        err (sticky watchdog flag), bus (gauss_pass_sched_if.master: memory + filter side).
// Option: define GSCHED_TIMEOUT_EN to enable the per-pass TMO-cycle watchdog.
module gauss_pass_sched
  import gauss_pkg::*;
#(
  parameter int WIDE   = 230,
  parameter int HIGN   = 235,
  parameter int DW     = 16,
  parameter int CNT_DW = 16,
  parameter int AW     = 20,
  parameter int NSCALE = 5,
  parameter int FLUSH  = 1410,
  parameter int TMO    = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done,
  output logic err,
  gauss_pass_sched_if.master bus
);
  localparam logic [AW-1:0] FRM_A = AW'(frm(WIDE, HIGN));
  state_t st, nx;
  logic [KW-1:0] s;
  logic [AW-1:0] cnt, r_addr, r_off, w_addr, w_off;
  logic rd_q, fl_q, act, acc, w_full, tmo_hit;
  assign act    = st inside {STREAM, gauss_pkg::FLUSH, DRAIN};
  assign w_full = w_off == FRM_A;
  assign acc    = act && bus.filt_vout && !w_full;
  gauss_addr_gen #(
    .WIDE(WIDE), .HIGN(HIGN), .CNT_DW(CNT_DW), .AW(AW), .BASE_OFS(0)
  ) u_rd (
    .clk(clk), .rst(rst), .clr(st == CLR), .inc(st == STREAM), .scale(s),
    .addr(r_addr), .off(r_off)
  );
  gauss_addr_gen #(
    .WIDE(WIDE), .HIGN(HIGN), .CNT_DW(CNT_DW), .AW(AW), .BASE_OFS(1)
  ) u_wr (
    .clk(clk), .rst(rst), .clr(st == CLR), .inc(acc), .scale(s),
    .addr(w_addr), .off(w_off)
  );
`ifdef GSCHED_TIMEOUT_EN
  logic [31:0] tcnt;
  always_ff @(posedge clk)
    if (!rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= act ? tcnt + 1'b1 : '0;
      err  <= (st == IDLE && start) ? 1'b0 : err | tmo_hit;
    end
  assign tmo_hit = act && !w_full && tcnt == 32'(TMO - 1);
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif
  always_ff @(posedge clk)
    st <= !rst ? IDLE : nx;
  // cnt measures cycles spent in the current state (CLR length, FLUSH length)
  always_ff @(posedge clk)
    if (!rst) begin
      cnt  <= '0;
      s    <= '0;
      rd_q <= 1'b0;
      fl_q <= 1'b0;
    end else begin
      cnt  <= (st != nx) ? '0 : cnt + 1'b1;
      s    <= (st == DONE) ? '0 : (st == NEXT && nx == CLR) ? s + 1'b1 : s;
      rd_q <= st == STREAM;
      fl_q <= st == gauss_pkg::FLUSH;
    end
  always_comb begin
    nx = st;
    case (st)
      IDLE:             nx = start ? CLR : IDLE;
      CLR:              nx = (cnt == AW'(1)) ? STREAM : CLR;
      STREAM:           nx = (r_off == FRM_A - 1'b1) ? gauss_pkg::FLUSH : STREAM;
      gauss_pkg::FLUSH: nx = (cnt == AW'(FLUSH - 1)) ? DRAIN : gauss_pkg::FLUSH;
      DRAIN:            nx = w_full ? NEXT : DRAIN;
      NEXT:             nx = (s == KW'(NSCALE - 1)) ? DONE : CLR;
      DONE:             nx = IDLE;
      default:          nx = IDLE;
    endcase
    if (tmo_hit) nx = DONE;
  end
  // filter input is the read stream delayed by the memory latency, followed back-to-back by flush zeros
  always_comb begin
    busy           = st != IDLE;
    done           = st == DONE;
    bus.rd_en      = st == STREAM;
    bus.rd_addr    = (st == STREAM) ? r_addr : '0;
    bus.wr_en      = acc;
    bus.wr_addr    = acc ? w_addr : '0;
    bus.wr_data    = acc ? bus.filt_dout : DW'(0);
    bus.filt_rst   = st != CLR;
    bus.filt_valid = rd_q | fl_q;
    bus.filt_data  = rd_q ? bus.rd_data : DW'(0);
    bus.filt_kern  = s;
  end
endmodule
